// File: rtl/bist_misr_checker.sv
// BIST response analyser: compacts CUT response beats in a Galois MISR and,
// after NUM_PATTERNS beats, compares the final signature against GOLDEN.
module bist_misr_checker #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] POLY         = 8'h1D,
    parameter logic [WIDTH-1:0] SEED         = 8'h00,
    parameter int               NUM_PATTERNS = 4,
    parameter logic [WIDTH-1:0] GOLDEN       = 8'h6C,
    localparam int              CW           = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CW-1:0]    beat_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_PATTERNS - 1);

    state_t state, state_nxt;
    logic   load, shift;

    function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] sig,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] fb_mask;
        fb_mask = sig[WIDTH-1] ? POLY : '0;
        return {sig[WIDTH-2:0], 1'b0} ^ fb_mask ^ d;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start takes priority over a coincident beat: the loading edge uses SEED.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COMPACT;
                    load      = 1'b1;
                end
            end
            COMPACT: begin
                if (resp_valid) begin
                    shift = 1'b1;
                    if (beat_count == LAST_BEAT) begin
                        state_nxt = COMPARE;
                    end
                end
            end
            COMPARE: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nxt = COMPACT;
                    load      = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signature  <= SEED;
            beat_count <= '0;
            pass       <= 1'b0;
        end else begin
            if (load) begin
                signature  <= SEED;
                beat_count <= '0;
                pass       <= 1'b0;
            end else if (shift) begin
                signature  <= misr_next(signature, resp_data);
                beat_count <= beat_count + CW'(1);
            end
            if (state == COMPARE) begin
                pass <= (signature == GOLDEN);
            end
        end
    end

    assign busy = (state == COMPACT) || (state == COMPARE);
    assign done = (state == DONE);

endmodule

// File: doc/bist_misr_checker.md
Name: bist_misr_checker

Overview:
Response-analysis end of the on-chip BIST. It receives circuit-under-test responses beat by beat and compacts them in a Galois MISR. After a fixed pattern count it compares the final signature against a golden value and reports pass/fail. It is the consumer counterpart of the pattern generator: the generator drives the CUT inputs, and this block judges the CUT outputs.

Parameters:
WIDTH, 8, response and signature width in bits (>=2).
POLY, 8'h1D, feedback tap mask XORed in when the MISR MSB is 1.
SEED, 8'h00, MISR value loaded on start.
NUM_PATTERNS, 4, response beats compacted per run (>=1).
GOLDEN, 8'h6C, expected final signature.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin a run; sampled only in IDLE or DONE
resp_valid  input  1  resp_data holds a CUT response this cycle
resp_data  input  WIDTH  CUT response beat
busy  output  1  high in COMPACT and COMPARE
done  output  1  high in DONE; result is valid
pass  output  1  final signature == GOLDEN; meaningful only while done=1
signature  output  WIDTH  current MISR contents
beat_count  output  $clog2(NUM_PATTERNS+1)  beats accepted in the current run

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; signature=SEED; beat_count=0; busy=0; done=0; pass=0.
  - Reset asserted mid-run aborts the run immediately. No partial result is reported.
- States and transitions:
  - IDLE: start=1 -> COMPACT on the next edge; that edge loads signature=SEED and beat_count=0.
  - COMPACT: each edge with resp_valid=1 updates the MISR and increments beat_count. resp_valid=0 holds everything; gaps of any length are allowed. When the accepted beat is beat number NUM_PATTERNS (beat_count was NUM_PATTERNS-1), move to COMPARE on that same edge.
  - COMPARE: lasts exactly one cycle. The edge registers pass=(signature==GOLDEN) and moves to DONE.
  - DONE: done=1; pass and signature are held. start=1 -> COMPACT with the same reload as from IDLE; done and pass clear on that edge.
- MISR update:
  - fb = signature[WIDTH-1].
  - next = (signature<<1, truncated to WIDTH) XOR (fb ? POLY : 0) XOR resp_data.
- Latency: the final beat is accepted at edge N; done=1 and pass are valid after edge N+1.
- Ignored inputs:
  - resp_valid outside COMPACT has no effect.
  - start while busy=1 has no effect. A run cannot be restarted except by reset.
- Beat limits: beat_count never exceeds NUM_PATTERNS. With NUM_PATTERNS=1, the first valid beat goes directly to COMPARE.
- Simultaneous start and resp_valid in IDLE/DONE: start wins. The beat is not compacted, because the loading edge uses SEED.
- Width rules: all MISR arithmetic is WIDTH bits; shift-out bits are discarded. Comparison is full-width equality.
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.

Test Plan:
1. Default parameters; start; 4 beats of 8'hFF back-to-back -> signature sequence 8'h00, FF, 1C, C7, 6C; done=1 one edge after the 4th beat; pass=1; busy=0.
2. Same as test 1, but the 4th beat is 8'hFE -> final signature 8'h6D; done=1, pass=0.
3. The test 1 beats with resp_valid=0 gaps of 0, 3 and 1 cycles between them -> identical signature 8'h6C and pass=1; beat_count steps 0,1,2,3 only on valid cycles.
4. rst=0 asynchronously after 2 beats (signature=8'h1C) -> immediately busy=0, done=0, pass=0, signature=8'h00, state IDLE. A subsequent full run of 4×8'hFF gives pass=1.
5. In DONE with pass=1: pulse start with resp_valid=1 and data 8'h55 -> that beat is ignored, signature=8'h00, done and pass clear. Then 4×8'hFF -> pass=1 again.
6. During COMPACT: pulse start and inject resp_valid beats before start and after done -> no restart and no signature change outside COMPACT; beat_count saturates at 4.
